mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store memory access controller.
// Holds the access-size and FSM state encodings plus the default timeout.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mac_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

    // An access is misaligned when any of the low size bits of the address are set.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic res;
        case (size)
            SIZE_BYTE:   res = 1'b0;
            SIZE_HALF:   res = off[0];
            SIZE_WORD:   res = |off[1:0];
            SIZE_DOUBLE: res = |off;
            default:     res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] res;
        case (size)
            SIZE_BYTE:   res = 8'h01;
            SIZE_HALF:   res = 8'h03;
            SIZE_WORD:   res = 8'h0F;
            SIZE_DOUBLE: res = 8'hFF;
            default:     res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and the 64-bit memory bus: store mask and
// data shifting on the way out, load data extraction and extension on the way in.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [2:0]  i_st_off,
    input  logic [63:0] i_st_wdata,
    output logic [7:0]  o_st_mask,
    output logic [63:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [2:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [63:0] i_ld_rdata,
    output logic [63:0] o_ld_data
);

    logic [63:0] w_ld_shifted;

    // Store path: shift mask and data up to the addressed byte lane.
    always_comb begin
        o_st_mask  = size_mask(i_st_size) << i_st_off;
        o_st_wdata = i_st_wdata << {i_st_off, 3'b000};
    end

    // Load path: bring the addressed lane down to bit 0, then extend to 64 bits.
    always_comb begin
        w_ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
        o_ld_data    = 64'd0;
        case (i_ld_size)
            SIZE_BYTE:   o_ld_data = i_ld_unsigned ? {56'd0, w_ld_shifted[7:0]}
                                                   : {{56{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            SIZE_HALF:   o_ld_data = i_ld_unsigned ? {48'd0, w_ld_shifted[15:0]}
                                                   : {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            SIZE_WORD:   o_ld_data = i_ld_unsigned ? {32'd0, w_ld_shifted[31:0]}
                                                   : {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
            SIZE_DOUBLE: o_ld_data = w_ld_shifted;
            default:     o_ld_data = 64'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller between a core request port and a
// 64-bit memory: alignment check, one-cycle strobe issue, bounded wait, held response.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        ioMem_ren,
    output logic        ioMem_wen,
    output logic [31:0] ioMem_addr,
    output logic [63:0] ioMem_wData,
    output logic [7:0]  ioMem_wMask,
    input  logic [63:0] ioMem_rData,
    input  logic        ioMem_rvalid,
    input  logic        ioMem_hit
);

    localparam logic [4:0] LAST_WAIT_CNT = 5'(TIMEOUT_CYCLES - 1);

    mac_state_e  r_state;
    mac_state_e  w_state_nxt;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;

    logic        r_wen;
    logic [1:0]  r_size;
    logic [2:0]  r_off;
    logic        r_unsigned;
    logic [4:0]  r_wait_cnt;

    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [31:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic [7:0]  r_mem_wmask;
    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_resp_err;

    logic [7:0]  w_st_mask;
    logic [63:0] w_st_wdata;
    logic [63:0] w_ld_data;

    mem_lane_align u_lane_align (
        .i_st_size     (req_size),
        .i_st_off      (req_addr[2:0]),
        .i_st_wdata    (req_wdata),
        .o_st_mask     (w_st_mask),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (ioMem_rData),
        .o_ld_data     (w_ld_data)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_misaligned = addr_misaligned(req_size, req_addr[2:0]);
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misaligned ? ST_RESP : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = r_wen ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (ioMem_rvalid) begin
                    w_state_nxt = ST_RESP;
                end else if (r_wait_cnt == LAST_WAIT_CNT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, memory strobes, wait counter and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen        <= 1'b0;
            r_size       <= 2'd0;
            r_off        <= 3'd0;
            r_unsigned   <= 1'b0;
            r_wait_cnt   <= 5'd0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 64'd0;
            r_mem_wmask  <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wen      <= req_wen;
                        r_size     <= req_size;
                        r_off      <= req_addr[2:0];
                        r_unsigned <= req_unsigned;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 64'd0;
                        end else begin
                            r_mem_ren   <= ~req_wen;
                            r_mem_wen   <= req_wen;
                            r_mem_addr  <= {req_addr[31:3], 3'b000};
                            r_mem_wdata <= req_wen ? w_st_wdata : 64'd0;
                            r_mem_wmask <= req_wen ? w_st_mask : 8'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= 5'd0;
                    if (r_wen) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 64'd0;
                    end
                end
                ST_WAIT: begin
                    if (ioMem_rvalid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ~ioMem_hit;
                        r_resp_rdata <= ioMem_hit ? w_ld_data : 64'd0;
                    end else if (w_timeout) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 64'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 5'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 64'd0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign ioMem_ren   = r_mem_ren;
    assign ioMem_wen   = r_mem_wen;
    assign ioMem_addr  = r_mem_addr;
    assign ioMem_wData = r_mem_wdata;
    assign ioMem_wMask = r_mem_wmask;

endmodule
